// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and index-width helper for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// arb_picker: combinational winner selection, round-robin after last_idx or lowest-index-first.
module arb_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RR_MODE = 1,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_idx,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      win_idx,
    output logic               any_req
);

    int   j;
    logic found;

    assign any_req = |req;

    // Integer modulo keeps the wrap correct when NUM_REQ is not a power of two.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (RR_MODE != 0) ? (int'(last_idx) + 1 + k) % NUM_REQ : k;
            if (!found && (req & (NUM_REQ'(1) << j)) != '0) begin
                found   = 1'b1;
                winner  = NUM_REQ'(1) << j;
                win_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-client arbiter for the shared memory port; the granted command is
// latched and held stable until mem_ready completes it.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int RR_MODE       = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               store_to_mem,
    input  logic [NUM_REQ-1:0]               store_word,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr_to_mem,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    data_to_mem,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               done,
    input  logic                             mem_ready,
    output logic                             request_to_mem_o,
    output logic                             store_to_mem_o,
    output logic                             store_word_to_mem_o,
    output logic [ADDRESS_WIDTH-1:0]         addr_to_mem_o,
    output logic [DATA_WIDTH-1:0]            data_to_mem_o
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_e               state_q, state_d;
    logic [IW-1:0]            last_q, last_d, win_idx;
    logic [NUM_REQ-1:0]       grant_q, grant_d, winner;
    logic                     req_q, req_d, st_q, st_d, sw_q, sw_d, any_req;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;

    arb_picker #(.NUM_REQ(NUM_REQ), .RR_MODE(RR_MODE)) u_picker (
        .req      (req),
        .last_idx (last_q),
        .winner   (winner),
        .win_idx  (win_idx),
        .any_req  (any_req)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        req_d   = req_q;
        st_d    = st_q;
        sw_d    = sw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (state_q == ARB_IDLE) begin
            if (any_req) begin
                state_d = ARB_BUSY;
                last_d  = win_idx;
                grant_d = winner;
                req_d   = 1'b1;
                st_d    = |(store_to_mem & winner);
                sw_d    = |(store_word & winner);
                addr_d  = '0;
                data_d  = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (winner[i]) begin
                        addr_d = addr_to_mem[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        data_d = data_to_mem[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end else if (mem_ready) begin
            // Clearing the whole command keeps every output at 0 while idle.
            state_d = ARB_IDLE;
            grant_d = '0;
            req_d   = 1'b0;
            st_d    = 1'b0;
            sw_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            req_q   <= 1'b0;
            st_q    <= 1'b0;
            sw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            st_q    <= st_d;
            sw_q    <= sw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign done                = (state_q == ARB_BUSY && mem_ready) ? grant_q : '0;
    assign grant               = grant_q;
    assign request_to_mem_o    = req_q;
    assign store_to_mem_o      = st_q;
    assign store_word_to_mem_o = sw_q;
    assign addr_to_mem_o       = addr_q;
    assign data_to_mem_o       = data_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: round-robin (4 and 3 clients) and fixed-priority instances driven by
// table vectors and hand sequences; expected outputs go through a scoreboard queue.
module tb_mem_arbiter_rr;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [3:0] req;
        logic [2:0] rc;
        logic       mr;
        logic [3:0] ga;
        logic [3:0] gb;
        logic [2:0] gc;
        logic       dn;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] ga, da, gb, db;
        logic [2:0] gc, dc;
        logic       rqa, rqb, rqc, stv, swv;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] req = '0;
    logic [2:0] req_c = '0;
    logic mr = 1'b0;
    logic [3:0] st_pat = 4'b0101;
    logic [3:0] sw_pat = 4'b0100;
    logic [AW-1:0] a_tab [4] = '{32'h050, 32'h100, 32'h040, 32'h300};
    logic [DW-1:0] d_tab [4] = '{32'hD0D0_0000, 32'hD1D1_1111, 32'hD2D2_2222, 32'hD3D3_3333};
    logic [AW-1:0] a_in [4];
    logic [4*AW-1:0] addr_bus;
    logic [4*DW-1:0] data_bus;

    logic [3:0] ga, da, gb, db;
    logic [2:0] gc, dc;
    logic rqa, sta, swa, rqb, stb, swb, rqc, stc, swc;
    logic [AW-1:0] aa, ab, ac;
    logic [DW-1:0] dda, ddb, ddc;

    exp_t sb[$];
    vec_t rr_tbl[17];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        addr_bus = '0;
        data_bus = '0;
        for (int i = 0; i < 4; i++) begin
            addr_bus[i*AW +: AW] = a_in[i];
            data_bus[i*DW +: DW] = d_tab[i];
        end
    end

    mem_arbiter_rr #(.NUM_REQ(4), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) u_a (
        .clk(clk), .reset_n(reset_n), .req(req), .store_to_mem(st_pat), .store_word(sw_pat),
        .addr_to_mem(addr_bus), .data_to_mem(data_bus), .grant(ga), .done(da), .mem_ready(mr),
        .request_to_mem_o(rqa), .store_to_mem_o(sta), .store_word_to_mem_o(swa),
        .addr_to_mem_o(aa), .data_to_mem_o(dda)
    );

    mem_arbiter_rr #(.NUM_REQ(4), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .req(req), .store_to_mem(st_pat), .store_word(sw_pat),
        .addr_to_mem(addr_bus), .data_to_mem(data_bus), .grant(gb), .done(db), .mem_ready(mr),
        .request_to_mem_o(rqb), .store_to_mem_o(stb), .store_word_to_mem_o(swb),
        .addr_to_mem_o(ab), .data_to_mem_o(ddb)
    );

    mem_arbiter_rr #(.NUM_REQ(3), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) u_c (
        .clk(clk), .reset_n(reset_n), .req(req_c), .store_to_mem(st_pat[2:0]),
        .store_word(sw_pat[2:0]), .addr_to_mem(addr_bus[3*AW-1:0]),
        .data_to_mem(data_bus[3*DW-1:0]), .grant(gc), .done(dc), .mem_ready(mr),
        .request_to_mem_o(rqc), .store_to_mem_o(stc), .store_word_to_mem_o(swc),
        .addr_to_mem_o(ac), .data_to_mem_o(ddc)
    );

    function automatic vec_t V(input logic [3:0] r, input logic [2:0] rc, input logic m,
                               input logic [3:0] xa, input logic [3:0] xb,
                               input logic [2:0] xc, input logic dn);
        vec_t v;
        v.req = r; v.rc = rc; v.mr = m; v.ga = xa; v.gb = xb; v.gc = xc; v.dn = dn;
        return v;
    endfunction

    task automatic chk();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: queue empty, got 0 entries, need 1");
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (ga !== e.ga || da !== e.da || rqa !== e.rqa || sta !== e.stv || swa !== e.swv ||
            aa !== e.addr || dda !== e.data || gb !== e.gb || db !== e.db || rqb !== e.rqb ||
            gc !== e.gc || dc !== e.dc || rqc !== e.rqc) begin
            miscompares++;
            $display("FAIL %s: got ga=%b da=%b rq=%b st=%b sw=%b addr=%h data=%h gb=%b db=%b rqb=%b gc=%b dc=%b rqc=%b | want ga=%b da=%b rq=%b st=%b sw=%b addr=%h data=%h gb=%b db=%b rqb=%b gc=%b dc=%b rqc=%b",
                     e.name, ga, da, rqa, sta, swa, aa, dda, gb, db, rqb, gc, dc, rqc,
                     e.ga, e.da, e.rqa, e.stv, e.swv, e.addr, e.data, e.gb, e.db, e.rqb,
                     e.gc, e.dc, e.rqc);
        end
    endtask

    // Drive one cycle's inputs just after the edge, queue the expectation, check at negedge.
    task automatic cyc(input string nm, input vec_t v);
        exp_t e;
        int w;
        req   = v.req;
        req_c = v.rc;
        mr    = v.mr;
        w = -1;
        for (int i = 0; i < 4; i++) if (v.ga[i]) w = i;
        e.name = nm;
        e.ga = v.ga;  e.gb = v.gb;  e.gc = v.gc;
        e.da = v.dn ? v.ga : 4'b0;
        e.db = v.dn ? v.gb : 4'b0;
        e.dc = v.dn ? v.gc : 3'b0;
        e.rqa = |v.ga; e.rqb = |v.gb; e.rqc = |v.gc;
        e.stv = |(st_pat & v.ga);
        e.swv = |(sw_pat & v.ga);
        e.addr = (w < 0) ? '0 : a_tab[w];
        e.data = (w < 0) ? '0 : d_tab[w];
        sb.push_back(e);
        @(negedge clk);
        chk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        vectors++;
        if ({ga, da, rqa, sta, swa, aa, dda, gb, db, rqb, gc, dc, rqc} !== '0) begin
            miscompares++;
            $display("FAIL %s: got ga=%b da=%b rq=%b addr=%h gb=%b rqb=%b gc=%b rqc=%b, want all 0",
                     nm, ga, da, rqa, aa, gb, rqb, gc, rqc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        // all four held high; mem_ready also pulsed in IDLE cycles, which must be ignored
        rr_tbl[0]  = V(4'hF, 3'h7, 0, 4'b0000, 4'b0000, 3'b000, 0);
        rr_tbl[1]  = V(4'hF, 3'h7, 0, 4'b0001, 4'b0001, 3'b001, 0);
        rr_tbl[2]  = V(4'hF, 3'h7, 1, 4'b0001, 4'b0001, 3'b001, 1);
        rr_tbl[3]  = V(4'hF, 3'h7, 1, 4'b0000, 4'b0000, 3'b000, 0);
        rr_tbl[4]  = V(4'hF, 3'h7, 0, 4'b0010, 4'b0001, 3'b010, 0);
        rr_tbl[5]  = V(4'hF, 3'h7, 1, 4'b0010, 4'b0001, 3'b010, 1);
        rr_tbl[6]  = V(4'hF, 3'h7, 0, 4'b0000, 4'b0000, 3'b000, 0);
        rr_tbl[7]  = V(4'hF, 3'h7, 0, 4'b0100, 4'b0001, 3'b100, 0);
        rr_tbl[8]  = V(4'hF, 3'h7, 1, 4'b0100, 4'b0001, 3'b100, 1);
        rr_tbl[9]  = V(4'hF, 3'h7, 0, 4'b0000, 4'b0000, 3'b000, 0);
        rr_tbl[10] = V(4'hF, 3'h7, 0, 4'b1000, 4'b0001, 3'b001, 0);
        rr_tbl[11] = V(4'hF, 3'h7, 1, 4'b1000, 4'b0001, 3'b001, 1);
        rr_tbl[12] = V(4'hF, 3'h7, 0, 4'b0000, 4'b0000, 3'b000, 0);
        rr_tbl[13] = V(4'hF, 3'h7, 0, 4'b0001, 4'b0001, 3'b010, 0);
        rr_tbl[14] = V(4'hF, 3'h7, 1, 4'b0001, 4'b0001, 3'b010, 1);
        rr_tbl[15] = V(4'h0, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0);
        rr_tbl[16] = V(4'h0, 3'h0, 1, 4'b0000, 4'b0000, 3'b000, 0);

        for (int k = 0; k < 4; k++) a_in[k] = a_tab[k];

        // reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            req = 4'($urandom);
            req_c = 3'($urandom);
            mr = 1'($urandom);
            a_in[k] = $urandom;
            @(negedge clk);
            chk_zero($sformatf("reset[%0d]", k));
        end
        for (int k = 0; k < 4; k++) a_in[k] = a_tab[k];
        req = '0;
        req_c = '0;
        mr = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 17; k++) cyc($sformatf("rr[%0d]", k), rr_tbl[k]);

        // single load from requester 1, completion four cycles later
        cyc("load0", V(4'b0010, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));
        cyc("load1", V(4'b0010, 3'h0, 0, 4'b0010, 4'b0010, 3'b000, 0));
        cyc("load2", V(4'b0010, 3'h0, 0, 4'b0010, 4'b0010, 3'b000, 0));
        cyc("load3", V(4'b0010, 3'h0, 0, 4'b0010, 4'b0010, 3'b000, 0));
        cyc("load4", V(4'b0010, 3'h0, 1, 4'b0010, 4'b0010, 3'b000, 1));
        cyc("load5", V(4'b0000, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));

        // fixed priority keeps picking requester 0 until 0 and 1 drop
        cyc("fp0", V(4'b1011, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));
        cyc("fp1", V(4'b1011, 3'h0, 0, 4'b1000, 4'b0001, 3'b000, 0));
        cyc("fp2", V(4'b1011, 3'h0, 1, 4'b1000, 4'b0001, 3'b000, 1));
        cyc("fp3", V(4'b1011, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));
        cyc("fp4", V(4'b1011, 3'h0, 0, 4'b0001, 4'b0001, 3'b000, 0));
        cyc("fp5", V(4'b1011, 3'h0, 1, 4'b0001, 4'b0001, 3'b000, 1));
        cyc("fp6", V(4'b1000, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));
        cyc("fp7", V(4'b1000, 3'h0, 0, 4'b1000, 4'b1000, 3'b000, 0));
        cyc("fp8", V(4'b0000, 3'h0, 1, 4'b1000, 4'b1000, 3'b000, 1));
        cyc("fp9", V(4'b0000, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));

        // granted requester moves its address and drops req while busy
        cyc("frz0", V(4'b0100, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));
        a_in[2] = 32'h080;
        cyc("frz1", V(4'b0000, 3'h0, 0, 4'b0100, 4'b0100, 3'b000, 0));
        cyc("frz2", V(4'b0000, 3'h0, 0, 4'b0100, 4'b0100, 3'b000, 0));
        cyc("frz3", V(4'b0000, 3'h0, 0, 4'b0100, 4'b0100, 3'b000, 0));
        cyc("frz4", V(4'b0000, 3'h0, 1, 4'b0100, 4'b0100, 3'b000, 1));
        a_in[2] = a_tab[2];
        cyc("frz5", V(4'b0000, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));

        // asynchronous reset while busy, then pointer restarts at requester 0
        cyc("ar0", V(4'b0001, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));
        cyc("ar1", V(4'b0000, 3'h0, 0, 4'b0001, 4'b0001, 3'b000, 0));
        reset_n = 1'b0;
        #2;
        chk_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post0", V(4'b1100, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));
        cyc("post1", V(4'b1100, 3'h0, 0, 4'b0100, 4'b0100, 3'b000, 0));
        cyc("post2", V(4'b0000, 3'h0, 1, 4'b0100, 4'b0100, 3'b000, 1));
        cyc("post3", V(4'b0000, 3'h0, 0, 4'b0000, 4'b0000, 3'b000, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
